// File: rtl/uart_mem_bridge.sv
// ============================================================================
// Module   : uart_mem_bridge
// Brief    : UART command-frame to 32-bit word bus debug bridge (write/read word).
//            Optional inter-byte timeout enabled by defining UART_BRIDGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_mem_bridge #(
  parameter logic [7:0] CMD_WRITE = 8'h57,
  parameter logic [7:0] CMD_READ  = 8'h52,
  parameter logic [7:0] ACK_BYTE  = 8'h4B,
  parameter logic [7:0] NAK_BYTE  = 8'h3F
`ifdef UART_BRIDGE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic        mem_ack,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_TX     = 3'd4;
  localparam logic [2:0] S_TXWAIT = 3'd5;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [1:0]  r_byte_cnt;
  logic        r_is_write;
  logic [31:0] r_reply;
  logic [2:0]  r_tx_left;
  logic        w_last_byte;
  logic        w_known_cmd;
  logic        w_drop;
  logic        w_timeout;

  assign w_last_byte = rx_valid && (r_byte_cnt == 2'd3);
  assign w_known_cmd = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
  assign w_drop      = rx_valid &&
                       ((r_state == S_MEM) || (r_state == S_TX) || (r_state == S_TXWAIT));

`ifdef UART_BRIDGE_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic        w_tmo_active;

  assign w_tmo_active = (r_state == S_ADDR) || (r_state == S_DATA);
  // Counter restarts on every received byte, so a timeout never coincides with rx_valid.
  assign w_timeout    = w_tmo_active && !rx_valid && (r_tmo_cnt >= (TIMEOUT_CYCLES - 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= 32'd0;
    end else if (rx_valid || !w_tmo_active) begin
      r_tmo_cnt <= 32'd0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          w_state_nxt = w_known_cmd ? S_ADDR : S_TX;
        end
      end
      S_ADDR: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (w_last_byte) begin
          w_state_nxt = r_is_write ? S_DATA : S_MEM;
        end
      end
      S_DATA: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (w_last_byte) begin
          w_state_nxt = S_MEM;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          w_state_nxt = S_TX;
        end
      end
      S_TX: begin
        w_state_nxt = S_TXWAIT;
      end
      S_TXWAIT: begin
        if (tx_done) begin
          w_state_nxt = (r_tx_left != 3'd0) ? S_TX : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_we  = 1'b0;
    mem_rd  = 1'b0;
    tx_send = 1'b0;
    tx_data = 8'h00;
    busy    = (r_state != S_IDLE);
    if (r_state == S_MEM) begin
      mem_we = r_is_write;
      mem_rd = !r_is_write;
    end
    if (r_state == S_TX) begin
      tx_send = 1'b1;
      tx_data = r_reply[31:24];
    end
  end

  // Frame capture: address/data only shift in their own states, so they hold through MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= 2'd0;
      r_is_write <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_byte_cnt <= 2'd0;
          if (rx_valid) begin
            r_is_write <= (rx_data == CMD_WRITE);
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            mem_addr   <= {mem_addr[23:0], rx_data};
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            mem_wdata  <= {mem_wdata[23:0], rx_data};
          end
        end
        default: begin
          r_byte_cnt <= 2'd0;
        end
      endcase
    end
  end

  // Reply buffer is sent MSB first by shifting left one byte per tx_send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reply   <= 32'd0;
      r_tx_left <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_valid && !w_known_cmd) begin
            r_reply   <= {NAK_BYTE, 24'h000000};
            r_tx_left <= 3'd1;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (r_is_write) begin
              r_reply   <= {ACK_BYTE, 24'h000000};
              r_tx_left <= 3'd1;
            end else begin
              r_reply   <= mem_rdata;
              r_tx_left <= 3'd4;
            end
          end
        end
        S_TX: begin
          r_reply   <= {r_reply[23:0], 8'h00};
          r_tx_left <= r_tx_left - 3'd1;
        end
        default: begin
          r_reply   <= r_reply;
          r_tx_left <= r_tx_left;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'h00;
    end else if (w_drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'h01;
    end
  end

endmodule

`default_nettype wire
